// File: rtl/csa_mp_add_seq.sv
// Multi-precision add sequencer: streams NWORDS-word operands LSB-first through a single
// 32-bit carry-select adder. Define MP_ADD_SUB_EN to add the in_sub (A - B) port.
module csa_mp_add_seq #(
  parameter int unsigned NWORDS = 4,
  parameter int unsigned WORD_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NWORDS*WORD_W-1:0] in_a,
  input  logic [NWORDS*WORD_W-1:0] in_b,
  input  logic                     in_cin,
`ifdef MP_ADD_SUB_EN
  input  logic                     in_sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NWORDS*WORD_W-1:0] out_sum,
  output logic                     out_cout,
  output logic                     busy
);

  localparam int unsigned IdxW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned OpW   = NWORDS * WORD_W;
  localparam int unsigned HalfW = WORD_W / 2;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NWORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [OpW-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            carry_q, carry_d, cout_q, cout_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            sub_q, sub_d;

  logic [WORD_W-1:0] a_word, b_word, b_eff, s_word;
  logic [HalfW:0]    lo_sum, hi_sum0, hi_sum1;
  logic              c_word;

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_word = a_q[i*WORD_W +: WORD_W];
        b_word = b_q[i*WORD_W +: WORD_W];
      end
    end
  end

  assign b_eff = sub_q ? ~b_word : b_word;

  // Carry-select: upper half is precomputed for both carries, lower-half carry picks one.
  assign lo_sum  = {1'b0, a_word[HalfW-1:0]} + {1'b0, b_eff[HalfW-1:0]}
                 + {{HalfW{1'b0}}, carry_q};
  assign hi_sum0 = {1'b0, a_word[WORD_W-1:HalfW]} + {1'b0, b_eff[WORD_W-1:HalfW]};
  assign hi_sum1 = {1'b0, a_word[WORD_W-1:HalfW]} + {1'b0, b_eff[WORD_W-1:HalfW]}
                 + {{HalfW{1'b0}}, 1'b1};
  assign s_word  = {lo_sum[HalfW] ? hi_sum1[HalfW-1:0] : hi_sum0[HalfW-1:0],
                    lo_sum[HalfW-1:0]};
  assign c_word  = lo_sum[HalfW] ? hi_sum1[HalfW] : hi_sum0[HalfW];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          idx_d   = '0;
          state_d = StRun;
`ifdef MP_ADD_SUB_EN
          sub_d   = in_sub;
          carry_d = in_sub ? 1'b1 : in_cin;
`else
          sub_d   = 1'b0;
          carry_d = in_cin;
`endif
        end
      end
      StRun: begin
        for (int i = 0; i < NWORDS; i++) begin
          if (idx_q == IdxW'(i)) sum_d[i*WORD_W +: WORD_W] = s_word;
        end
        carry_d = c_word;
        if (idx_q == LastIdx) begin
          cout_d  = c_word;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule

// File: tb/tb_csa_mp_add_seq.sv
// Randomized self-checking bench for csa_mp_add_seq against a wide-arithmetic model.
module tb_csa_mp_add_seq;

  localparam int unsigned NW = 4;
  localparam int unsigned W  = NW * 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_cin;
  logic [W-1:0] in_a, in_b, out_sum;
  logic         out_valid, out_ready, out_cout, busy;
`ifdef MP_ADD_SUB_EN
  logic         in_sub;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  csa_mp_add_seq #(.NWORDS(NW), .WORD_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef MP_ADD_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic, {cout, sum}.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] r;
    for (int i = 0; i < NW; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic sub);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
`ifdef MP_ADD_SUB_EN
    in_sub   = sub;
`else
    if (sub) $display("note: subtract requested in add-only build");
`endif
  endtask

  task automatic scramble_inputs();
    in_valid = 1'b0;
    in_a     = rand_op();
    in_b     = rand_op();
    in_cin   = 1'($urandom);
`ifdef MP_ADD_SUB_EN
    in_sub   = 1'($urandom);
`endif
  endtask

  // Accept a request, wait for the result, check latency/value, then release it.
  task automatic do_req(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
    logic [W:0] exp;
    int cyc;
    exp = ref_add(a, b, cin, sub);
    check_eq({tag, ".ready"}, in_ready, 1);
    drive_req(a, b, cin, sub);
    tick();
    scramble_inputs();
    check_eq({tag, ".busy"}, busy, 1);
    check_eq({tag, ".rdy_lo"}, in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 4 * NW + 8) begin
      tick();
      cyc++;
    end
    check_eq({tag, ".lat"}, cyc, NW);
    check_eq({tag, ".sum"}, {out_cout, out_sum}, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, ".vld_lo"}, out_valid, 0);
    check_eq({tag, ".idle"}, in_ready, 1);
  endtask

  initial begin
    logic [W:0]   held;
    logic [W-1:0] ones;
    logic         sub;
    ones      = '1;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    scramble_inputs();
    #1;
    check_eq("rst.ready", in_ready, 1);
    check_eq("rst.valid", out_valid, 0);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.sum", {out_cout, out_sum}, 0);
    #12 rst_n = 1'b1;
    tick();

    do_req("small", W'(8), W'(9), 1'b0, 1'b0);
    do_req("xword", {64'h0, 64'hFFFF_FFFF_FFFF_FFFE}, W'(2), 1'b0, 1'b0);
    do_req("ovf", ones, W'(0), 1'b1, 1'b0);

    // Backpressure: result must hold while new requests are offered and ignored.
    drive_req(rand_op(), rand_op(), 1'b1, 1'b0);
    held = ref_add(in_a, in_b, 1'b1, 1'b0);
    tick();
    scramble_inputs();
    for (int i = 0; i < NW; i++) tick();
    check_eq("bp.first", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      drive_req(rand_op(), rand_op(), 1'($urandom), 1'b0);
      tick();
      check_eq("bp.valid", out_valid, 1);
      check_eq("bp.ready", in_ready, 0);
      check_eq("bp.sum", {out_cout, out_sum}, held);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp.release", out_valid, 0);
    check_eq("bp.idle", busy, 0);
    tick();
    check_eq("bp.noacc", busy, 0);

    // Reset in the middle of RUN (idx=2), asserted away from the clock edge.
    drive_req(rand_op(), rand_op(), 1'b1, 1'b0);
    tick();
    scramble_inputs();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("mrst.ready", in_ready, 1);
    check_eq("mrst.valid", out_valid, 0);
    check_eq("mrst.busy", busy, 0);
    check_eq("mrst.sum", {out_cout, out_sum}, 0);
    #3 rst_n = 1'b1;
    tick();
    do_req("post_rst", W'(33), W'(66), 1'b1, 1'b0);
`ifdef MP_ADD_SUB_EN
    do_req("sub", W'(5), W'(7), 1'b1, 1'b1);
`endif

    for (int t = 0; t < 40; t++) begin
`ifdef MP_ADD_SUB_EN
      sub = 1'($urandom);
`else
      sub = 1'b0;
`endif
      case (t % 4)
        0:       do_req("rnd", rand_op(), rand_op(), 1'($urandom), sub);
        1:       do_req("rnd_ones", ones, rand_op(), 1'($urandom), sub);
        2:       do_req("rnd_eq", in_a, in_a, 1'($urandom), sub);
        default: do_req("rnd_lo", W'($urandom), ~W'(0) - W'($urandom_range(3)), 1'b1, sub);
      endcase
      if ($urandom_range(3) == 0) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
